bcd_countdown: RTL and testbench

Loadable, pausable multi-digit BCD down counter: the counting-down counterpart of the team's free-running 4-bit up counters. A BCD value is preloaded and started; the block decrements once per prescaled tick and stops at zero. On reaching zero it raises a one-cycle `done` pulse. It drives a display or sequencing logic directly and replaces ad-hoc count-to-limit counters wherever a terminal event is needed.

---
 rtl/bcd_countdown_pkg.sv | 17 +
 rtl/bcd_digit_dec.sv | 24 ++
 rtl/bcd_countdown.sv | 117 +++++++++++
 tb/tb_bcd_countdown.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_pkg.sv
// Shared types and helpers for the loadable BCD down counter.
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer with borrow in/out; chained LSD first.
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [3:0] d,
    input  logic       borrow_in,
    output logic [3:0] d_next,
    output logic       borrow_out
);

    always_comb begin
        d_next     = d;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (d == 4'd0) begin
                d_next     = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                d_next = d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Loadable, pausable multi-digit BCD down counter with prescaled tick and done pulse.
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   q,
    output logic                  busy,
    output logic                  done,
    output logic                  load_err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV) + 1;

    state_t          state, state_nx;
    logic [W-1:0]    q_nx;
    logic [W-1:0]    q_dec;
    logic [PW-1:0]   presc, presc_nx;
    logic            busy_nx, done_nx, err_nx;
    logic            tick;
    logic            load_ok;
    logic [DIGITS:0] borrow;

    // Prescaler wrap while counting; pause level blocks it on the same edge.
    assign tick      = ((state == RUN) || (state == PAUSE)) && !pause
                       && (presc == PW'(TICK_DIV - 1));
    assign borrow[0] = tick;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
        bcd_digit_dec u_dig (
            .d          (q[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .d_next     (q_dec[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!bcd_valid(load_val[4*i +: 4])) load_ok = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        q_nx     = q;
        presc_nx = presc;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (load) begin
                    if (load_ok) begin
                        q_nx     = load_val;
                        state_nx = IDLE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (start && (q != '0)) begin
                    state_nx = RUN;
                    presc_nx = '0;
                end
            end
            RUN, PAUSE: begin
                if (pause) begin
                    state_nx = PAUSE;
                end else begin
                    state_nx = RUN;
                    if (tick) begin
                        presc_nx = '0;
                        // A borrow out of the top digit would mean underflow; hold at zero.
                        if (!borrow[DIGITS]) begin
                            q_nx = q_dec;
                            if (q_dec == '0) begin
                                state_nx = DONE;
                                done_nx  = 1'b1;
                            end
                        end
                    end else begin
                        presc_nx = presc + PW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == RUN) || (state_nx == PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= '0;
            presc    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            q        <= q_nx;
            presc    <= presc_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            load_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: vector table on a TICK_DIV=1 instance plus corner sequences.
module tb_bcd_countdown;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       load1, start1, pause1;
    logic [7:0] lv1, q1;
    logic       busy1, done1, err1;

    logic       load4, start4, pause4;
    logic [7:0] lv4, q4;
    logic       busy4, done4, err4;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       ld;
        logic [7:0] lv;
        logic       st;
        logic       ps;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    bcd_countdown #(.DIGITS(2), .TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .load_val(lv1), .start(start1),
        .pause(pause1), .q(q1), .busy(busy1), .done(done1), .load_err(err1)
    );

    bcd_countdown #(.DIGITS(2), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .load_val(lv4), .start(start4),
        .pause(pause4), .q(q4), .busy(busy4), .done(done4), .load_err(err4)
    );

    function automatic vec_t mk(logic ld, logic [7:0] lv, logic st, logic ps,
                                logic [7:0] q, logic b, logic d, logic e);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.ps = ps;
        v.q = q; v.busy = b; v.done = d; v.err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until q4 matches or the budget runs out; reports edges taken.
    task automatic wait_q4(input logic [7:0] exp, input int max, output int n);
        n = 0;
        while (q4 !== exp && n < max) begin
            step();
            n++;
        end
        chk($sformatf("wait_q4_%h", exp), q4, exp);
    endtask

    initial begin
        int n;

        rst_n = 1'b0;
        load1 = 0; start1 = 0; pause1 = 0; lv1 = '0;
        load4 = 0; start4 = 0; pause4 = 0; lv4 = '0;

        // Table: TICK_DIV=1 instance, one row per clock edge.
        tbl[0]  = mk(1, 8'h34, 0, 0, 8'h34, 0, 0, 0);
        tbl[1]  = mk(1, 8'h3A, 0, 0, 8'h34, 0, 0, 1);
        tbl[2]  = mk(0, 8'h00, 0, 0, 8'h34, 0, 0, 0);
        tbl[3]  = mk(1, 8'h99, 0, 0, 8'h99, 0, 0, 0);
        tbl[4]  = mk(1, 8'h50, 1, 0, 8'h50, 0, 0, 0);
        tbl[5]  = mk(0, 8'h00, 0, 0, 8'h50, 0, 0, 0);
        tbl[6]  = mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        tbl[8]  = mk(1, 8'h12, 0, 0, 8'h12, 0, 0, 0);
        tbl[9]  = mk(0, 8'h00, 1, 0, 8'h12, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 0, 1, 8'h12, 1, 0, 0);
        tbl[11] = mk(1, 8'h07, 0, 1, 8'h12, 1, 0, 0);
        tbl[12] = mk(0, 8'h00, 0, 0, 8'h11, 1, 0, 0);
        tbl[13] = mk(1, 8'h07, 0, 0, 8'h10, 1, 0, 0);
        tbl[14] = mk(0, 8'h00, 1, 0, 8'h09, 1, 0, 0);
        for (int k = 8; k >= 1; k--)
            tbl[23 - k] = mk(0, 8'h00, 0, 0, 8'(k), 1, 0, 0);
        tbl[23] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        tbl[24] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        tbl[25] = mk(1, 8'h0F, 0, 0, 8'h00, 0, 0, 1);
        tbl[26] = mk(1, 8'h45, 0, 0, 8'h45, 0, 0, 0);

        repeat (2) step();
        chk("rst_q1", q1, 8'h00);
        chk("rst_busy1", {7'd0, busy1}, 8'h00);
        chk("rst_done1", {7'd0, done1}, 8'h00);
        chk("rst_err1", {7'd0, err1}, 8'h00);
        chk("rst_q4", q4, 8'h00);
        chk("rst_busy4", {7'd0, busy4}, 8'h00);
        chk("rst_done4", {7'd0, done4}, 8'h00);
        chk("rst_err4", {7'd0, err4}, 8'h00);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            load1 = tbl[i].ld; lv1 = tbl[i].lv; start1 = tbl[i].st; pause1 = tbl[i].ps;
            step();
            chk($sformatf("v%0d_q", i), q1, tbl[i].q);
            chk($sformatf("v%0d_busy", i), {7'd0, busy1}, {7'd0, tbl[i].busy});
            chk($sformatf("v%0d_done", i), {7'd0, done1}, {7'd0, tbl[i].done});
            chk($sformatf("v%0d_err", i), {7'd0, err1}, {7'd0, tbl[i].err});
        end
        load1 = 0; start1 = 0; pause1 = 0;

        // Asynchronous reset in the middle of a count.
        load1 = 1; lv1 = 8'h25; step();
        load1 = 0; start1 = 1; step();
        start1 = 0;
        repeat (3) step();
        chk("mid_q_before_rst", q1, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q1, 8'h00);
        chk("async_rst_busy", {7'd0, busy1}, 8'h00);
        chk("async_rst_done", {7'd0, done1}, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_done", {7'd0, done1}, 8'h00);
        chk("post_rst_q", q1, 8'h00);

        // Pause on TICK_DIV=4 instance.
        load4 = 1; lv4 = 8'h03; step();
        chk("p_load", q4, 8'h03);
        load4 = 0; start4 = 1; step();
        start4 = 0;
        chk("p_busy_start", {7'd0, busy4}, 8'h01);
        wait_q4(8'h02, 12, n);
        chk("p_first_dec_lat", 8'(n), 8'd4);
        pause4 = 1;
        repeat (10) step();
        chk("p_frozen_q", q4, 8'h02);
        chk("p_frozen_busy", {7'd0, busy4}, 8'h01);
        pause4 = 0;
        wait_q4(8'h01, 20, n);
        chk("p_resume_lat", 8'(n), 8'd4);
        wait_q4(8'h00, 20, n);
        chk("p_final_lat", 8'(n), 8'd4);
        chk("p_done_pulse", {7'd0, done4}, 8'h01);
        chk("p_busy_end", {7'd0, busy4}, 8'h00);
        step();
        chk("p_done_clear", {7'd0, done4}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
